// File: rtl/fft_pease_band_energy_detector.sv
// fft_pease_band_energy_detector
//   Sums |X[k]| over bins [BIN_LO, BIN_HI] of a serialized spectrum frame
//   (one signed bin per beat, bin 0 first, N_SAMPLES bins per frame). At the
//   end of each frame it presents the band energy and a detect flag
//   (energy >= threshold latched on bin 0) until the consumer accepts it.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   recv_msg/recv_val/recv_rdy  bin stream in (valid/ready)
//   threshold                   unsigned detect threshold, sampled on bin 0
//   send_energy/send_detect     registered frame result
//   send_val/send_rdy           result handshake
module fft_pease_band_energy_detector #(
    parameter int BIT_WIDTH = 32,
    parameter int N_SAMPLES = 8,
    parameter int BIN_LO    = 1,
    parameter int BIN_HI    = 3,
    parameter int ACC_WIDTH = BIT_WIDTH + $clog2(N_SAMPLES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BIT_WIDTH-1:0] recv_msg,
    input  logic                 recv_val,
    output logic                 recv_rdy,
    input  logic [ACC_WIDTH-1:0] threshold,
    output logic [ACC_WIDTH-1:0] send_energy,
    output logic                 send_detect,
    output logic                 send_val,
    input  logic                 send_rdy
);
    localparam int IDX_W = $clog2(N_SAMPLES);

    generate
        if (BIN_HI >= N_SAMPLES) begin : g_chk_hi
            $error("BIN_HI must be < N_SAMPLES");
        end
        if (BIN_LO > BIN_HI) begin : g_chk_lo
            $error("BIN_LO must be <= BIN_HI");
        end
        if (N_SAMPLES < 2 || (N_SAMPLES & (N_SAMPLES - 1)) != 0) begin : g_chk_n
            $error("N_SAMPLES must be a power of 2 and >= 2");
        end
        if (ACC_WIDTH < BIT_WIDTH) begin : g_chk_acc
            $error("ACC_WIDTH must be >= BIT_WIDTH");
        end
    endgenerate

    typedef enum logic {ACCUM, DONE} state_t;

    state_t               state, next_state;
    logic [IDX_W-1:0]     idx;
    logic [ACC_WIDTH-1:0] acc, acc_next, thr_q;
    logic [BIT_WIDTH-1:0] mag;
    logic [ACC_WIDTH:0]   sum;
    logic                 accept, last, in_band;

    assign accept  = recv_val && (state == ACCUM);
    assign last    = (idx == IDX_W'(N_SAMPLES - 1));
    assign in_band = (int'(idx) >= BIN_LO) && (int'(idx) <= BIN_HI);

    // Two's-complement negate; the most negative input maps onto itself,
    // which read as unsigned is exactly its magnitude.
    assign mag = recv_msg[BIT_WIDTH-1] ? (~recv_msg + 1'b1) : recv_msg;

    // One extra bit catches the carry out so the sum can clamp instead of wrap.
    assign sum      = {1'b0, acc} + {{(ACC_WIDTH + 1 - BIT_WIDTH){1'b0}}, mag};
    assign acc_next = !in_band        ? acc :
                      sum[ACC_WIDTH]  ? {ACC_WIDTH{1'b1}} :
                                        sum[ACC_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) state <= ACCUM;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        recv_rdy   = 1'b0;
        send_val   = 1'b0;
        case (state)
            ACCUM: begin
                recv_rdy = 1'b1;
                if (accept && last) next_state = DONE;
            end
            DONE: begin
                send_val = 1'b1;
                if (send_rdy) next_state = ACCUM;
            end
            default: next_state = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx         <= '0;
            acc         <= '0;
            thr_q       <= '0;
            send_energy <= '0;
            send_detect <= 1'b0;
        end else if (accept) begin
            if (idx == '0) thr_q <= threshold;
            idx <= idx + 1'b1;
            acc <= acc_next;
            if (last) begin
                // thr_q was captured on bin 0, which is always an earlier beat.
                send_energy <= acc_next;
                send_detect <= (acc_next >= thr_q);
            end
        end else if (state == DONE && send_rdy) begin
            idx <= '0;
            acc <= '0;
        end
    end
endmodule

// File: tb/tb_fft_pease_band_energy_detector.sv
module tb_fft_pease_band_energy_detector;
    localparam int AW  = 35;
    localparam int AWS = 32;

    typedef logic signed [31:0] frame_t [8];
    typedef struct { logic [63:0] e; logic d; } exp_t;

    logic           clk = 1'b0;
    logic           reset;
    logic [31:0]    recv_msg;
    logic           recv_val;
    logic           recv_rdy, recv_rdy_s;
    logic [AW-1:0]  threshold;
    logic [AW-1:0]  send_energy;
    logic [AWS-1:0] send_energy_s;
    logic           send_detect, send_detect_s;
    logic           send_val, send_val_s;
    logic           send_rdy;

    int   checks = 0;
    int   fails  = 0;
    exp_t q_main[$];
    exp_t q_sat[$];

    always #5 clk = ~clk;

    fft_pease_band_energy_detector u_dut (
        .clk(clk), .reset(reset), .recv_msg(recv_msg), .recv_val(recv_val),
        .recv_rdy(recv_rdy), .threshold(threshold), .send_energy(send_energy),
        .send_detect(send_detect), .send_val(send_val), .send_rdy(send_rdy)
    );

    fft_pease_band_energy_detector #(.ACC_WIDTH(AWS)) u_sat (
        .clk(clk), .reset(reset), .recv_msg(recv_msg), .recv_val(recv_val),
        .recv_rdy(recv_rdy_s), .threshold(threshold[AWS-1:0]),
        .send_energy(send_energy_s), .send_detect(send_detect_s),
        .send_val(send_val_s), .send_rdy(send_rdy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: saturating sum of magnitudes over bins 1..3.
    function automatic exp_t model(input frame_t f, input logic [AW-1:0] thr, input int aw);
        exp_t r;
        longint sum = 0;
        longint mx  = (longint'(1) << aw) - 1;
        for (int k = 1; k <= 3; k++)
            sum += (f[k] < 0) ? -longint'(f[k]) : longint'(f[k]);
        if (sum > mx) sum = mx;
        r.e = 64'(sum);
        r.d = (sum >= (longint'(thr) & mx));
        return r;
    endfunction

    task automatic wait_rdy();
        int n = 0;
        while (!recv_rdy && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("rdy_timeout", 64'd0, 64'd1);
    endtask

    // Drives one frame; returns #1 after the edge that accepted the last bin.
    task automatic send_frame(input frame_t f, input logic [AW-1:0] thr,
                              input bit gaps, input bit thr_mid_zero, input bit push);
        if (push) begin
            q_main.push_back(model(f, thr, AW));
            q_sat.push_back(model(f, thr, AWS));
        end
        for (int i = 0; i < 8; i++) begin
            if (gaps) begin
                recv_val = 1'b0;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            recv_msg = f[i];
            recv_val = 1'b1;
            if (i == 0) threshold = thr;
            wait_rdy();
            @(posedge clk); #1;
            if (i == 0 && thr_mid_zero) threshold = '0;
        end
        recv_val = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (send_val && send_rdy) begin
                if (q_main.size() == 0) chk("unexpected_out", 64'd1, 64'd0);
                else begin
                    e = q_main.pop_front();
                    chk("energy", 64'(send_energy), e.e);
                    chk("detect", 64'(send_detect), 64'(e.d));
                end
            end
            if (send_val_s && send_rdy) begin
                if (q_sat.size() == 0) chk("unexpected_out_sat", 64'd1, 64'd0);
                else begin
                    e = q_sat.pop_front();
                    chk("energy_sat", 64'(send_energy_s), e.e);
                    chk("detect_sat", 64'(send_detect_s), 64'(e.d));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        frame_t f1, f2, f3, f4, f5;
        logic [AW-1:0] e_hold;
        f1 = '{5, 10, -20, 30, 100, 100, 100, 100};
        f2 = '{-7, -1, 2, -3, 0, 0, 0, 9};
        f3 = '{1000, -1, -2, -4, 7, 7, 7, 7};
        f4 = '{0, 32'h80000000, 0, 0, 0, 0, 0, 0};
        f5 = '{0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 1, 1, 1, 1};

        reset = 1'b1; recv_msg = '0; recv_val = 1'b0; threshold = '0; send_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_recv_rdy", 64'(recv_rdy), 64'd1);
        chk("rst_send_val", 64'(send_val), 64'd0);
        chk("rst_energy", 64'(send_energy), 64'd0);
        chk("rst_detect", 64'(send_detect), 64'd0);

        // Basic frame, result one cycle after the last beat.
        send_frame(f1, 35'd60, 1'b0, 1'b0, 1'b1);
        chk("latency_val", 64'(send_val), 64'd1);
        wait_rdy();

        // Threshold just above; mid-frame change must be ignored.
        send_frame(f1, 35'd61, 1'b0, 1'b1, 1'b1);
        wait_rdy();

        // Back-pressure: outputs held, no beats consumed.
        send_rdy = 1'b0;
        send_frame(f1, 35'd60, 1'b0, 1'b0, 1'b1);
        e_hold   = send_energy;
        recv_val = 1'b1;
        recv_msg = 32'd999;
        repeat (5) begin
            @(negedge clk);
            chk("hold_val", 64'(send_val), 64'd1);
            chk("hold_energy", 64'(send_energy), 64'(e_hold));
            chk("hold_recv_rdy", 64'(recv_rdy), 64'd0);
        end
        recv_val = 1'b0;
        @(posedge clk); #1;
        send_rdy = 1'b1;
        wait_rdy();
        send_frame(f2, 35'd6, 1'b0, 1'b0, 1'b1);
        wait_rdy();

        // Most negative input.
        send_frame(f4, 35'h0_8000_0000, 1'b0, 1'b0, 1'b1);
        wait_rdy();
        send_frame(f4, 35'h0_8000_0001, 1'b0, 1'b0, 1'b1);
        wait_rdy();

        // Saturation in the narrow-accumulator instance.
        send_frame(f5, 35'h0_FFFF_FFFF, 1'b0, 1'b0, 1'b1);
        wait_rdy();

        // Random gaps give the gap-free result.
        send_frame(f1, 35'd60, 1'b1, 1'b0, 1'b1);
        wait_rdy();

        // Partial frame then reset: only the post-reset frame counts.
        for (int i = 0; i < 4; i++) begin
            recv_msg = f5[i];
            recv_val = 1'b1;
            wait_rdy();
            @(posedge clk); #1;
        end
        recv_val = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst2_recv_rdy", 64'(recv_rdy), 64'd1);
        chk("rst2_send_val", 64'(send_val), 64'd0);
        send_frame(f3, 35'd8, 1'b0, 1'b0, 1'b1);
        wait_rdy();

        repeat (4) @(posedge clk);
        chk("q_main_drained", 64'(q_main.size()), 64'd0);
        chk("q_sat_drained", 64'(q_sat.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
